// File: rtl/out_alu_collect_unit.sv
// Collects adder and multiplier results into one-deep holding registers and
// drains them round-robin into the FIFO_OUT write port, with debug counters.
module out_alu_collect_unit #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 4,
  parameter int CNT_SIZE       = 8,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_result_valid,
  input  logic [DATA_SIZE-1:0]      a_result,
  input  logic [ID_SIZE-1:0]        id_add,
  output logic                      a_result_ready,
  input  logic                      m_result_valid,
  input  logic [DATA_SIZE-1:0]      m_result,
  input  logic [ID_SIZE-1:0]        id_mul,
  output logic                      m_result_ready,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic [CNT_SIZE-1:0]       add_cnt,
  output logic [CNT_SIZE-1:0]       mul_cnt,
  output logic                      proto_err
);

  typedef enum logic {PRIO_ADD = 1'b0, PRIO_MUL = 1'b1} prio_e;

  logic [DATA_SIZE-1:0] a_res_q, m_res_q;
  logic [ID_SIZE-1:0]   a_id_q, m_id_q;
  logic                 a_full_q, a_full_d;
  logic                 m_full_q, m_full_d;
  prio_e                prio_q, prio_d;
  logic [CNT_SIZE-1:0]  add_cnt_q, add_cnt_d;
  logic [CNT_SIZE-1:0]  mul_cnt_q, mul_cnt_d;
  logic                 proto_q, proto_d;

  logic grant_vld, grant_mul, a_take, m_take, a_drain, m_drain;

  // Ready depends only on holding state, so full_out never reaches the ALU combinationally.
  assign a_result_ready = !a_full_q;
  assign m_result_ready = !m_full_q;
  assign a_take         = a_result_valid && !a_full_q;
  assign m_take         = m_result_valid && !m_full_q;

  always_comb begin
    grant_vld = !full_out && (a_full_q || m_full_q);
    grant_mul = m_full_q && (!a_full_q || (prio_q == PRIO_MUL));
    a_drain   = grant_vld && !grant_mul;
    m_drain   = grant_vld && grant_mul;
  end

  always_comb begin
    fifo_out_data = '0;
    if (grant_vld) begin
      if (grant_mul) fifo_out_data = {m_res_q, m_id_q, 1'b1};
      else           fifo_out_data = {a_res_q, a_id_q, 1'b0};
    end
  end

  assign w_en_out  = grant_vld;
  assign add_cnt   = add_cnt_q;
  assign mul_cnt   = mul_cnt_q;
  assign proto_err = proto_q;

  // A full hold cannot capture, so capture and drain never collide on one edge.
  always_comb begin
    a_full_d  = a_full_q;
    m_full_d  = m_full_q;
    prio_d    = prio_q;
    add_cnt_d = add_cnt_q;
    mul_cnt_d = mul_cnt_q;
    proto_d   = proto_q | (a_result_valid & a_full_q) | (m_result_valid & m_full_q);
    if (a_take)  a_full_d = 1'b1;
    if (m_take)  m_full_d = 1'b1;
    if (a_drain) begin
      a_full_d  = 1'b0;
      prio_d    = PRIO_MUL;
      add_cnt_d = add_cnt_q + 1'b1;
    end
    if (m_drain) begin
      m_full_d  = 1'b0;
      prio_d    = PRIO_ADD;
      mul_cnt_d = mul_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full_q  <= 1'b0;
      m_full_q  <= 1'b0;
      prio_q    <= PRIO_ADD;
      add_cnt_q <= '0;
      mul_cnt_q <= '0;
      proto_q   <= 1'b0;
    end else begin
      a_full_q  <= a_full_d;
      m_full_q  <= m_full_d;
      prio_q    <= prio_d;
      add_cnt_q <= add_cnt_d;
      mul_cnt_q <= mul_cnt_d;
      proto_q   <= proto_d;
    end
  end

  // Payload registers carry no reset; their contents are only observed while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (a_take) begin
      a_res_q <= a_result;
      a_id_q  <= id_add;
    end
    if (m_take) begin
      m_res_q <= m_result;
      m_id_q  <= id_mul;
    end
  end

endmodule

// File: tb/tb_out_alu_collect_unit.sv
// Directed bench for out_alu_collect_unit: reset, single/simultaneous writes,
// backpressure, protocol violation and counter wrap.
module tb_out_alu_collect_unit;
  localparam int DATA_SIZE = 16;
  localparam int ID_SIZE   = 4;
  localparam int CNT_SIZE  = 8;
  localparam int FW        = DATA_SIZE + ID_SIZE + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 a_result_valid = 1'b0;
  logic [DATA_SIZE-1:0] a_result = '0;
  logic [ID_SIZE-1:0]   id_add = '0;
  logic                 a_result_ready;
  logic                 m_result_valid = 1'b0;
  logic [DATA_SIZE-1:0] m_result = '0;
  logic [ID_SIZE-1:0]   id_mul = '0;
  logic                 m_result_ready;
  logic                 full_out = 1'b0;
  logic                 w_en_out;
  logic [FW-1:0]        fifo_out_data;
  logic [CNT_SIZE-1:0]  add_cnt;
  logic [CNT_SIZE-1:0]  mul_cnt;
  logic                 proto_err;

  int checks = 0;
  int errors = 0;

  out_alu_collect_unit #(
    .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .CNT_SIZE(CNT_SIZE), .FIFO_OUT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst),
    .a_result_valid(a_result_valid), .a_result(a_result), .id_add(id_add),
    .a_result_ready(a_result_ready),
    .m_result_valid(m_result_valid), .m_result(m_result), .id_mul(id_mul),
    .m_result_ready(m_result_ready),
    .full_out(full_out), .w_en_out(w_en_out), .fifo_out_data(fifo_out_data),
    .add_cnt(add_cnt), .mul_cnt(mul_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_a_ready", 32'(a_result_ready), 32'd1);
    chk("rst_m_ready", 32'(m_result_ready), 32'd1);
    chk("rst_w_en",    32'(w_en_out),       32'd0);
    chk("rst_data",    32'(fifo_out_data),  32'd0);
    chk("rst_add_cnt", 32'(add_cnt),        32'd0);
    chk("rst_mul_cnt", 32'(mul_cnt),        32'd0);
    chk("rst_proto",   32'(proto_err),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [FW-1:0] exp_word;
    int            idle_writes;

    // Reset then idle
    tick();
    tick();
    pulse_reset();
    idle_writes = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_en_out !== 1'b0) idle_writes++;
      tick();
    end
    chk("idle_no_write", 32'(idle_writes), 32'd0);

    // Single add
    a_result_valid = 1'b1; a_result = 16'h00FF; id_add = 4'h3;
    tick();
    a_result_valid = 1'b0;
    exp_word = {16'h00FF, 4'h3, 1'b0};
    chk("single_w_en",    32'(w_en_out),       32'd1);
    chk("single_data",    32'(fifo_out_data),  32'(exp_word));
    chk("single_a_ready", 32'(a_result_ready), 32'd0);
    tick();
    chk("single_w_en_off", 32'(w_en_out),       32'd0);
    chk("single_add_cnt",  32'(add_cnt),        32'd1);
    chk("single_ready_up", 32'(a_result_ready), 32'd1);

    // Simultaneous capture, starting from prio=ADD
    pulse_reset();
    a_result_valid = 1'b1; a_result = 16'h0005; id_add = 4'h1;
    m_result_valid = 1'b1; m_result = 16'h0F0F; id_mul = 4'h2;
    tick();
    a_result_valid = 1'b0; m_result_valid = 1'b0;
    exp_word = {16'h0005, 4'h1, 1'b0};
    chk("sim_first_w_en", 32'(w_en_out),       32'd1);
    chk("sim_first_data", 32'(fifo_out_data),  32'(exp_word));
    chk("sim_m_ready_lo", 32'(m_result_ready), 32'd0);
    tick();
    exp_word = {16'h0F0F, 4'h2, 1'b1};
    chk("sim_second_w_en", 32'(w_en_out),       32'd1);
    chk("sim_second_data", 32'(fifo_out_data),  32'(exp_word));
    chk("sim_a_ready_up",  32'(a_result_ready), 32'd1);
    tick();
    chk("sim_idle",    32'(w_en_out), 32'd0);
    chk("sim_add_cnt", 32'(add_cnt),  32'd1);
    chk("sim_mul_cnt", 32'(mul_cnt),  32'd1);

    // Backpressure with both holds full; prio is back at ADD
    full_out = 1'b1;
    a_result_valid = 1'b1; a_result = 16'h1234; id_add = 4'h4;
    m_result_valid = 1'b1; m_result = 16'h5678; id_mul = 4'h5;
    tick();
    a_result_valid = 1'b0; m_result_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_write", 32'(w_en_out),       32'd0);
      chk("bp_data_zero", 32'(fifo_out_data), 32'd0);
      chk("bp_a_ready",  32'(a_result_ready), 32'd0);
      chk("bp_m_ready",  32'(m_result_ready), 32'd0);
      if (i < 4) tick();
    end
    full_out = 1'b0;
    #1;
    exp_word = {16'h1234, 4'h4, 1'b0};
    chk("bp_first_w_en", 32'(w_en_out),      32'd1);
    chk("bp_first_data", 32'(fifo_out_data), 32'(exp_word));
    tick();
    exp_word = {16'h5678, 4'h5, 1'b1};
    chk("bp_second_w_en", 32'(w_en_out),      32'd1);
    chk("bp_second_data", 32'(fifo_out_data), 32'(exp_word));
    tick();
    chk("bp_idle",    32'(w_en_out), 32'd0);
    chk("bp_add_cnt", 32'(add_cnt),  32'd2);
    chk("bp_mul_cnt", 32'(mul_cnt),  32'd2);

    // Protocol violation: valid held high while ready is low
    a_result_valid = 1'b1; a_result = 16'hAAAA; id_add = 4'h6;
    tick();
    a_result = 16'hBBBB; id_add = 4'h7;
    exp_word = {16'hAAAA, 4'h6, 1'b0};
    chk("pe_proto_before", 32'(proto_err),     32'd0);
    chk("pe_write_data",   32'(fifo_out_data), 32'(exp_word));
    tick();
    a_result_valid = 1'b0;
    chk("pe_proto_set", 32'(proto_err), 32'd1);
    chk("pe_no_second", 32'(w_en_out),  32'd0);
    idle_writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w_en_out !== 1'b0) idle_writes++;
    end
    chk("pe_one_word_only", 32'(idle_writes), 32'd0);
    chk("pe_add_cnt",       32'(add_cnt),     32'd3);
    chk("pe_sticky",        32'(proto_err),   32'd1);

    // Counter wrap: one mul, then 256 adds
    pulse_reset();
    m_result_valid = 1'b1; m_result = 16'h0001; id_mul = 4'h9;
    tick();
    m_result_valid = 1'b0;
    tick();
    chk("wrap_mul_pre", 32'(mul_cnt), 32'd1);
    for (int i = 0; i < 256; i++) begin
      a_result_valid = 1'b1; a_result = 16'(i); id_add = 4'(i);
      tick();
      a_result_valid = 1'b0;
      tick();
      if (i == 254) chk("wrap_add_255", 32'(add_cnt), 32'd255);
    end
    chk("wrap_add_zero",  32'(add_cnt),   32'd0);
    chk("wrap_mul_kept",  32'(mul_cnt),   32'd1);
    chk("wrap_proto_clr", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/out_alu_collect_unit.md
Name: out_alu_collect_unit

Overview:
- Downstream neighbour of the ALU input control stage: collects completed results from the adder and multiplier and writes them one at a time into FIFO_OUT.
- Each source gets a one-deep holding register with a ready/valid handshake.
- A round-robin arbiter drains the holding registers into the FIFO write port and respects full_out.
- Keeps per-source result counters and a sticky protocol-violation flag for debug.

Parameters:
- DATA_SIZE, 16, result width for both add and mul results (8x8 mul yields 16 bits).
- ID_SIZE, 4, transaction ID width carried alongside each result.
- CNT_SIZE, 8, width of the per-source written-result counters.
- FIFO_OUT_WIDTH, DATA_SIZE+ID_SIZE+1, FIFO_OUT word, packed as {result, id, op_tag}.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_result_valid  in  1  adder presents a result this cycle.
- a_result  in  DATA_SIZE  adder result.
- id_add  in  ID_SIZE  ID of the adder result.
- a_result_ready  out  1  add holding register can accept.
- m_result_valid  in  1  multiplier presents a result this cycle.
- m_result  in  DATA_SIZE  multiplier result.
- id_mul  in  ID_SIZE  ID of the multiplier result.
- m_result_ready  out  1  mul holding register can accept.
- full_out  in  1  FIFO_OUT full.
- w_en_out  out  1  FIFO_OUT write enable, one cycle per word.
- fifo_out_data  out  FIFO_OUT_WIDTH  word to write.
- add_cnt  out  CNT_SIZE  add results written to FIFO_OUT.
- mul_cnt  out  CNT_SIZE  mul results written to FIFO_OUT.
- proto_err  out  1  sticky: a valid arrived while the matching ready was low.

Behaviour:
- Reset (async, rst=1):
  - Both holding registers empty, so a_result_ready=m_result_ready=1.
  - w_en_out=0, fifo_out_data=0, add_cnt=mul_cnt=0, proto_err=0.
  - Round-robin pointer prio=ADD.
  - Reset mid-operation discards held results without writing them.
- Capture:
  - x_result_ready = !hold_x_full, a registered state with no combinational path from full_out.
  - On an edge with x_result_valid & x_result_ready, hold_x <= {result, id} and hold_x_full <= 1.
  - Each source therefore accepts at most one result every 2 cycles.
- Arbiter (combinational grant, registered effects). Define req_a = hold_a_full and req_m = hold_m_full. No grant when full_out=1 or no request. Otherwise:
  - Only one req: grant that source.
  - Both reqs: grant the source equal to prio.
- Write:
  - w_en_out = grant_valid, combinational.
  - fifo_out_data = {hold_g.result, hold_g.id, op_tag}, with op_tag 0 = add and 1 = mul.
  - fifo_out_data is 0 when there is no grant.
  - On that edge: hold_g_full <= 0, prio <= the other source, and cnt_g <= cnt_g+1, wrapping modulo 2^CNT_SIZE (255 -> 0).
- Latency: a result captured at edge N appears on w_en_out/fifo_out_data during cycle N+1, provided full_out=0 and it wins arbitration.
- full_out=1: no write, holding registers keep their contents, and ready stays low for full sources (backpressure reaches the ALU).
- Simultaneous events:
  - Both sources capture on the same edge: the prio source is written first, the other on the next free cycle.
  - A hold being drained does not accept on the same edge; its ready rises the following cycle.
- proto_err:
  - Set on any edge with x_result_valid=1 & x_result_ready=0; cleared only by rst.
  - The offending result is dropped and the held value is unchanged.
- Fairness: with both sources continuously requesting and full_out=0, writes alternate A,M,A,M.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 immediately, both readys=1, prio=ADD; no w_en_out for 20 cycles.
- Single add: a_result=16'h00FF, id_add=3 at edge N -> cycle N+1 w_en_out=1, fifo_out_data={16'h00FF,4'h3,1'b0}; add_cnt=1.
- Simultaneous: add 16'h0005/id1 and mul 16'h0F0F/id2 captured on the same edge -> add written first, mul on the next cycle with op_tag=1; prio ends at ADD; add_cnt=mul_cnt=1.
- Backpressure: full_out=1 for 5 cycles with both holds full -> no writes, readys=0, data held; full_out drops -> two writes in consecutive cycles with correct order.
- Protocol violation: second a_result_valid while a_result_ready=0 -> proto_err=1 sticky, hold keeps the first value, and exactly one add word is written.
- Counter wrap: 256 add results -> add_cnt returns to 0, and mul_cnt stays unchanged.
